hw2_sequence_receiver: RTL and testbench
========================================

Name: hw2_sequence_receiver

Overview:
Serial receiver for the bit stream produced by hw2_sequence_generator on data_out.
- Hunts the incoming stream for a sync pattern.
- Deserializes a fixed-width payload plus an even-parity bit.
- Presents each good frame as a parallel word on a valid/ready handshake.
- Sits downstream of the generator; feeds project-level checkers or scoreboards.

Parameters:
SYNC_W, 4, sync pattern length in bits
SYNC_PAT, 4'b1011, sync pattern; first bit received is the MSB
PAYLOAD_W, 8, payload bits per frame, received MSB first
CNT_W, 8, width of the good-frame counter

Ports:
clk  input  1  single clock; all logic on posedge clk
rst_n  input  1  asynchronous, active-low reset
data_in  input  1  serial bit from the generator's data_out
enable  input  1  bit-valid qualifier; data_in is sampled only when enable=1
frame_ready  input  1  consumer accepts frame_data
frame_data  output  PAYLOAD_W  received payload
frame_valid  output  1  frame_data holds an unconsumed good frame
parity_err  output  1  one-cycle pulse: frame dropped for a parity error
overflow  output  1  one-cycle pulse: good frame dropped because the holding register was full
busy  output  1  1 when the FSM is not in HUNT
frame_cnt  output  CNT_W  count of good frames loaded into the holding register; wraps

Behaviour:
Reset:
- Asynchronous on rst_n=0.
- FSM goes to HUNT; sync shift register, bit counter and payload register clear.
- All outputs are 0, including frame_data and frame_cnt.
- A reset mid-frame discards the partial frame and any held frame.

Enable gating:
- Cycles with enable=0 are invisible: the FSM holds, no shift, no counting.
- The handshake still operates on enable=0 cycles.

FSM states:
- HUNT:
  - Shift register sr (SYNC_W-1 bits) records the most recent sampled bits.
  - Sync is detected when {sr, data_in} == SYNC_PAT on an enabled cycle.
  - Detection is bit-overlapping; for example, 1,0,1,0,1,1 detects on the 6th bit.
  - On detect: go to PAYLOAD, bit_cnt=0, clear sr.
- PAYLOAD:
  - On each enabled cycle, payload <= {payload[PAYLOAD_W-2:0], data_in} and bit_cnt++.
  - After PAYLOAD_W bits, go to PARITY.
- PARITY:
  - On the next enabled cycle, sample the parity bit p.
  - Frame is good if ^payload ^ p == 0 (even parity).
  - Always return to HUNT with sr cleared; bits of the finished frame never count toward the next sync.

Frame completion (the PARITY sample cycle):
- Bad parity: parity_err=1 for the following cycle; frame dropped; frame_cnt unchanged.
- Good parity, and the holding register is empty or popped this cycle (frame_valid && frame_ready):
  - frame_data <= payload; frame_valid=1 from the next cycle.
  - frame_cnt++, wrapping from 2^CNT_W-1 to 0.
- Good parity, holding register full and not popped: overflow=1 for the following cycle; the held frame is kept unchanged; frame_cnt unchanged.

Latency:
- frame_valid rises one clock after the parity-bit sample.
- Minimum gap from sync start to valid: SYNC_W+PAYLOAD_W+1 enabled bits, plus 1 clock.

Handshake:
- frame_data is stable while frame_valid && !frame_ready.
- frame_valid clears the cycle after a handshake, unless a new frame loads in the same cycle; then it stays 1 with the new data.
- frame_ready while frame_valid=0 has no effect.

Pulses: parity_err and overflow are never asserted in the same cycle.

busy: combinational from state (state != HUNT).

Decomposition:
- Package hw2_seq_pkg:
  - typedef enum logic [1:0] {HUNT, PAYLOAD, PARITY} rx_state_t.
  - Default constants SYNC_W=4, SYNC_PAT=4'b1011, PAYLOAD_W=8, shared with the generator and its bench.
- Sub-module hw2_sync_hunter:
  - Holds the sync shift register and comparator.
  - Inputs: clk, rst_n, bit_in, bit_en, clear.
  - Output: sync_hit.
- FSM, deserializer, parity check, holding register and counter stay in the top module.

Test Plan:
1. Basic frame: frame_ready=1, enable=1; stream 1011, 10100101, 0 -> frame_data=8'hA5, frame_valid high for exactly 1 cycle, one clock after the parity bit; frame_cnt=1; parity_err=0.
2. Parity error: stream 1011, 10100101, 1 -> parity_err single pulse, frame_valid stays 0, frame_cnt=0; a following good frame 1011, 00111100, 0 -> 8'h3C, frame_cnt=1.
3. Overflow: frame_ready=0; frames A5 (parity 0) then 3C (parity 0) -> frame_data stays 8'hA5, overflow pulse after the second parity bit, frame_cnt=1. Raising frame_ready pops A5, then frame_valid=0.
4. Pop/load collision: frame_ready=1 asserted exactly on the parity cycle of frame 3C while A5 is held -> frame_valid remains 1, frame_data switches to 8'h3C, no overflow, frame_cnt=2.
5. Overlapping sync and enable gaps: stream 1,0,1,0,1,1 then payload A5, parity 0, with enable=0 for 3 random cycles inserted mid-payload -> sync detected on the 6th bit, frame_data=8'hA5; busy=1 from the cycle after sync until the cycle after parity.
6. Reset mid-operation: assert rst_n=0 after 4 payload bits, and separately with a frame held -> all outputs 0 immediately, FSM in HUNT; the next complete frame is received correctly with frame_cnt=1.

Source files
------------

// File: rtl/hw2_seq_pkg.sv
// rtl/hw2_seq_pkg.sv - shared constants and state type for the hw2 sequence generator/receiver pair
package hw2_seq_pkg;

    localparam int               SYNC_W    = 4;
    localparam logic [SYNC_W-1:0] SYNC_PAT = 4'b1011;
    localparam int               PAYLOAD_W = 8;
    localparam int               CNT_W     = 8;

    typedef enum logic [1:0] {
        HUNT,
        PAYLOAD,
        PARITY
    } rx_state_t;

endpackage

// File: rtl/hw2_sync_hunter.sv
// rtl/hw2_sync_hunter.sv - sliding-window sync pattern detector with synchronous clear
module hw2_sync_hunter #(
    parameter int                SYNC_W   = hw2_seq_pkg::SYNC_W,
    parameter logic [SYNC_W-1:0] SYNC_PAT = hw2_seq_pkg::SYNC_PAT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic bit_in,
    input  logic bit_en,
    input  logic clear,
    output logic sync_hit
);

    logic [SYNC_W-2:0] sr_q;
    logic [SYNC_W-2:0] sr_d;
    logic [SYNC_W-1:0] window;

    // The incoming bit completes the window, so detection needs no extra cycle.
    assign window   = {sr_q, bit_in};
    assign sync_hit = bit_en && (window == SYNC_PAT);

    always_comb begin
        sr_d = sr_q;
        if (clear) begin
            sr_d = '0;
        end else if (bit_en) begin
            sr_d = window[SYNC_W-2:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr_q <= '0;
        end else begin
            sr_q <= sr_d;
        end
    end

endmodule

// File: rtl/hw2_sequence_receiver.sv
// rtl/hw2_sequence_receiver.sv - sync hunt, payload deserializer, even-parity check and one-deep frame holding register
module hw2_sequence_receiver #(
    parameter int                SYNC_W    = hw2_seq_pkg::SYNC_W,
    parameter logic [SYNC_W-1:0] SYNC_PAT  = hw2_seq_pkg::SYNC_PAT,
    parameter int                PAYLOAD_W = hw2_seq_pkg::PAYLOAD_W,
    parameter int                CNT_W     = hw2_seq_pkg::CNT_W
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 data_in,
    input  logic                 enable,
    input  logic                 frame_ready,
    output logic [PAYLOAD_W-1:0] frame_data,
    output logic                 frame_valid,
    output logic                 parity_err,
    output logic                 overflow,
    output logic                 busy,
    output logic [CNT_W-1:0]     frame_cnt
);

    import hw2_seq_pkg::*;

    localparam int BCNT_W = (PAYLOAD_W > 1) ? $clog2(PAYLOAD_W) : 1;

    rx_state_t            state_q, state_d;
    logic [BCNT_W-1:0]    bit_cnt_q, bit_cnt_d;
    logic [PAYLOAD_W-1:0] payload_q, payload_d;
    logic [PAYLOAD_W-1:0] frame_data_q, frame_data_d;
    logic                 frame_valid_q, frame_valid_d;
    logic                 parity_err_q, parity_err_d;
    logic                 overflow_q, overflow_d;
    logic [CNT_W-1:0]     frame_cnt_q, frame_cnt_d;

    logic hunt_en;
    logic hunt_clear;
    logic sync_hit;
    logic pop;

    // The hunter only sees bits while hunting and is held clear otherwise,
    // so no bit of a finished frame can contribute to the next sync.
    assign hunt_en    = enable && (state_q == HUNT);
    assign hunt_clear = sync_hit || (state_q != HUNT);

    hw2_sync_hunter #(
        .SYNC_W   (SYNC_W),
        .SYNC_PAT (SYNC_PAT)
    ) u_sync_hunter (
        .clk      (clk),
        .rst_n    (rst_n),
        .bit_in   (data_in),
        .bit_en   (hunt_en),
        .clear    (hunt_clear),
        .sync_hit (sync_hit)
    );

    assign pop = frame_valid_q && frame_ready;

    always_comb begin
        state_d       = state_q;
        bit_cnt_d     = bit_cnt_q;
        payload_d     = payload_q;
        frame_data_d  = frame_data_q;
        frame_valid_d = frame_valid_q && !pop;
        parity_err_d  = 1'b0;
        overflow_d    = 1'b0;
        frame_cnt_d   = frame_cnt_q;

        case (state_q)
            HUNT: begin
                if (sync_hit) begin
                    state_d   = PAYLOAD;
                    bit_cnt_d = '0;
                end
            end
            PAYLOAD: begin
                if (enable) begin
                    payload_d = {payload_q[PAYLOAD_W-2:0], data_in};
                    bit_cnt_d = bit_cnt_q + BCNT_W'(1);
                    if (bit_cnt_q == BCNT_W'(PAYLOAD_W - 1)) begin
                        state_d = PARITY;
                    end
                end
            end
            PARITY: begin
                if (enable) begin
                    state_d = HUNT;
                    if ((^payload_q) ^ data_in) begin
                        parity_err_d = 1'b1;
                    end else if (!frame_valid_q || pop) begin
                        // A pop in the same cycle frees the slot for the new frame.
                        frame_data_d  = payload_q;
                        frame_valid_d = 1'b1;
                        frame_cnt_d   = frame_cnt_q + CNT_W'(1);
                    end else begin
                        overflow_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = HUNT;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= HUNT;
            bit_cnt_q     <= '0;
            payload_q     <= '0;
            frame_data_q  <= '0;
            frame_valid_q <= 1'b0;
            parity_err_q  <= 1'b0;
            overflow_q    <= 1'b0;
            frame_cnt_q   <= '0;
        end else begin
            state_q       <= state_d;
            bit_cnt_q     <= bit_cnt_d;
            payload_q     <= payload_d;
            frame_data_q  <= frame_data_d;
            frame_valid_q <= frame_valid_d;
            parity_err_q  <= parity_err_d;
            overflow_q    <= overflow_d;
            frame_cnt_q   <= frame_cnt_d;
        end
    end

    assign frame_data  = frame_data_q;
    assign frame_valid = frame_valid_q;
    assign parity_err  = parity_err_q;
    assign overflow    = overflow_q;
    assign busy        = (state_q != HUNT);
    assign frame_cnt   = frame_cnt_q;

endmodule

// File: tb/tb_hw2_sequence_receiver.sv
// tb/tb_hw2_sequence_receiver.sv - directed and randomized bench for hw2_sequence_receiver against a bit-stream model
module tb_hw2_sequence_receiver;

    localparam logic [3:0] PAT = 4'b1011;

    logic       clk;
    logic       rst_n;
    logic       data_in;
    logic       enable;
    logic       frame_ready;
    logic [7:0] frame_data;
    logic       frame_valid;
    logic       parity_err;
    logic       overflow;
    logic       busy;
    logic [7:0] frame_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    hw2_sequence_receiver dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .data_in     (data_in),
        .enable      (enable),
        .frame_ready (frame_ready),
        .frame_data  (frame_data),
        .frame_valid (frame_valid),
        .parity_err  (parity_err),
        .overflow    (overflow),
        .busy        (busy),
        .frame_cnt   (frame_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: bits collected since the last frame end, then the 9 frame bits.
    bit         hunt_q[$];
    bit         fbits[$];
    bit         m_in_frame;
    logic [7:0] m_data;
    logic       m_valid;
    logic       m_perr;
    logic       m_ovf;
    logic [7:0] m_cnt;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    task automatic model_reset();
        hunt_q.delete();
        fbits.delete();
        m_in_frame = 1'b0;
        m_data     = '0;
        m_valid    = 1'b0;
        m_perr     = 1'b0;
        m_ovf      = 1'b0;
        m_cnt      = '0;
    endtask

    task automatic model_step(input logic d, input logic en, input logic rdy);
        logic [7:0] pl;
        logic [3:0] w;
        int         ones;
        int         n;
        m_perr = 1'b0;
        m_ovf  = 1'b0;
        if (m_valid && rdy) m_valid = 1'b0;
        if (en) begin
            if (!m_in_frame) begin
                hunt_q.push_back(d);
                if (hunt_q.size() > 4) void'(hunt_q.pop_front());
                n = hunt_q.size();
                if (n == 4) begin
                    w = {hunt_q[0], hunt_q[1], hunt_q[2], hunt_q[3]};
                    if (w == PAT) begin
                        m_in_frame = 1'b1;
                        hunt_q.delete();
                        fbits.delete();
                    end
                end
            end else begin
                fbits.push_back(d);
                if (fbits.size() == 9) begin
                    pl   = '0;
                    ones = 0;
                    for (int i = 0; i < 9; i++) begin
                        if (i < 8) pl = {pl[6:0], 1'(fbits[i])};
                        ones += int'(fbits[i]);
                    end
                    m_in_frame = 1'b0;
                    fbits.delete();
                    if (ones % 2 != 0) begin
                        m_perr = 1'b1;
                    end else if (!m_valid) begin
                        m_data  = pl;
                        m_valid = 1'b1;
                        m_cnt   = m_cnt + 8'd1;
                    end else begin
                        m_ovf = 1'b1;
                    end
                end
            end
        end
    endtask

    task automatic check_outputs();
        check("frame_valid", 32'(frame_valid), 32'(m_valid));
        check("frame_data",  32'(frame_data),  32'(m_data));
        check("parity_err",  32'(parity_err),  32'(m_perr));
        check("overflow",    32'(overflow),    32'(m_ovf));
        check("busy",        32'(busy),        32'(m_in_frame));
        check("frame_cnt",   32'(frame_cnt),   32'(m_cnt));
    endtask

    task automatic cyc(input logic d, input logic en, input logic rdy);
        data_in     = d;
        enable      = en;
        frame_ready = rdy;
        @(posedge clk);
        model_step(d, en, rdy);
        #1;
        check_outputs();
    endtask

    task automatic do_reset();
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_outputs();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Sends sync + payload (MSB first) + parity; n_gaps disabled cycles land at random payload positions.
    task automatic send_frame(input logic [7:0] pl, input logic good, input logic rdy_body,
                              input logic rdy_par, input int n_gaps);
        logic [3:0] pat;
        int         gaps_left;
        pat       = PAT;
        gaps_left = n_gaps;
        for (int i = 3; i >= 0; i--) cyc(pat[i], 1'b1, rdy_body);
        for (int i = 7; i >= 0; i--) begin
            while (gaps_left > 0 && i < 7 && ($urandom_range(0, 1) == 1 || gaps_left >= i + 1)) begin
                cyc(1'($urandom_range(0, 1)), 1'b0, rdy_body);
                gaps_left--;
            end
            cyc(pl[i], 1'b1, rdy_body);
        end
        cyc(good ? ^pl : ~^pl, 1'b1, rdy_par);
    endtask

    initial begin
        rst_n       = 1'b0;
        data_in     = 1'b0;
        enable      = 1'b0;
        frame_ready = 1'b0;
        model_reset();
        #3;
        check_outputs();
        @(negedge clk);
        rst_n = 1'b1;

        // Basic frame with the consumer always ready
        send_frame(8'hA5, 1'b1, 1'b1, 1'b1, 0);
        check("t1_valid", 32'(frame_valid), 32'd1);
        check("t1_data", 32'(frame_data), 32'hA5);
        cyc(1'b0, 1'b1, 1'b1);
        check("t1_valid_drop", 32'(frame_valid), 32'd0);
        check("t1_cnt", 32'(frame_cnt), 32'd1);

        // Parity error followed by a good frame
        do_reset();
        send_frame(8'hA5, 1'b0, 1'b1, 1'b1, 0);
        check("t2_perr", 32'(parity_err), 32'd1);
        cyc(1'b0, 1'b1, 1'b1);
        check("t2_perr_pulse", 32'(parity_err), 32'd0);
        send_frame(8'h3C, 1'b1, 1'b1, 1'b1, 0);
        check("t2_data", 32'(frame_data), 32'h3C);
        check("t2_cnt", 32'(frame_cnt), 32'd1);

        // Overflow while holding, then drain
        do_reset();
        send_frame(8'hA5, 1'b1, 1'b0, 1'b0, 0);
        send_frame(8'h3C, 1'b1, 1'b0, 1'b0, 0);
        check("t3_ovf", 32'(overflow), 32'd1);
        check("t3_data", 32'(frame_data), 32'hA5);
        check("t3_cnt", 32'(frame_cnt), 32'd1);
        cyc(1'b0, 1'b1, 1'b1);
        check("t3_popped", 32'(frame_valid), 32'd0);

        // Pop and load in the same cycle
        do_reset();
        send_frame(8'hA5, 1'b1, 1'b0, 1'b0, 0);
        send_frame(8'h3C, 1'b1, 1'b0, 1'b1, 0);
        check("t4_valid", 32'(frame_valid), 32'd1);
        check("t4_data", 32'(frame_data), 32'h3C);
        check("t4_ovf", 32'(overflow), 32'd0);
        check("t4_cnt", 32'(frame_cnt), 32'd2);
        cyc(1'b0, 1'b1, 1'b1);

        // Overlapping sync prefix and enable gaps mid-payload
        do_reset();
        cyc(1'b1, 1'b1, 1'b1);
        cyc(1'b0, 1'b1, 1'b1);
        check("t5_idle", 32'(busy), 32'd0);
        send_frame(8'hA5, 1'b1, 1'b1, 1'b1, 3);
        check("t5_data", 32'(frame_data), 32'hA5);
        check("t5_busy_end", 32'(busy), 32'd0);

        // Reset mid-payload, reset with a frame held, then a clean frame
        do_reset();
        for (int i = 3; i >= 0; i--) cyc(PAT[i], 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) cyc(1'($urandom_range(0, 1)), 1'b1, 1'b0);
        check("t6_busy", 32'(busy), 32'd1);
        do_reset();
        check("t6_rst_busy", 32'(busy), 32'd0);
        send_frame(8'h5A, 1'b1, 1'b0, 1'b0, 0);
        do_reset();
        check("t6_rst_valid", 32'(frame_valid), 32'd0);
        send_frame(8'hC3, 1'b1, 1'b0, 1'b0, 0);
        check("t6_data", 32'(frame_data), 32'hC3);
        check("t6_cnt", 32'(frame_cnt), 32'd1);

        // Randomized traffic: noise bits, framed bursts, random enable and ready
        for (int it = 0; it < 400; it++) begin
            if ($urandom_range(0, 3) == 0) begin
                send_frame(8'($urandom), 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                           1'($urandom_range(0, 1)), int'($urandom_range(0, 3)));
            end else begin
                for (int k = 0; k < 8; k++) begin
                    cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) == 0));
                end
            end
            if ($urandom_range(0, 99) == 0) do_reset();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
